systolic_matmul: RTL and testbench



---
 rtl/systolic_matmul.sv | 143 ++++++++++++++
 tb/tb_systolic_matmul.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_matmul.sv
// systolic_matmul: N x N output-stationary systolic matrix multiplier.
// Computes C = A*B (or C += A*B) on unsigned operands using N*N registered MAC PEs.
// A streams in from the left edge and B from the top edge, each skewed by one cycle
// per row/column, so that A[i][k] and B[k][j] meet in PE(i,j) at RUN step i+k+j.
module systolic_matmul #(
  parameter int N  = 4,
  parameter int DW = 3,
  parameter int AW = 2*DW+$clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_accum,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*N*AW-1:0] c_flat,
  output logic              busy
);

  localparam int TW    = $clog2(3*N);
  localparam int TLAST = 3*N-2;
  localparam int PW    = (AW > 2*DW) ? AW : 2*DW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   t;
  logic            accept;
  logic            last_step;

  logic [DW-1:0]   a_op  [N][N];
  logic [DW-1:0]   b_op  [N][N];
  logic [DW-1:0]   a_pe  [N][N];
  logic [DW-1:0]   b_pe  [N][N];
  logic [AW-1:0]   acc   [N][N];
  logic [AW-1:0]   acc_nx[N][N];
  logic [DW-1:0]   a_inj [N];
  logic [DW-1:0]   b_inj [N];

  assign accept    = (state == IDLE) && in_valid;
  assign last_step = (state == RUN) && (t == TLAST[TW-1:0]);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake/status outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state == RUN);
    out_valid = (state == DONE);
  end

  // Skewed edge injection: row i gets A[i][t-i], column j gets B[t-j][j], else zero
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (32'(t) == i + k) begin
          a_inj[i] = a_op[i][k];
          b_inj[i] = b_op[k][i];
        end
      end
    end
  end

  // MAC: full 2*DW product, added modulo 2^AW
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        logic [PW-1:0] sum;
        sum = PW'(acc[i][j]) + PW'(PW'(a_pe[i][j]) * PW'(b_pe[i][j]));
        acc_nx[i][j] = sum[AW-1:0];
      end
    end
  end

  // Operand capture, PE pipeline shift, accumulation and step counter
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_op[i][j] <= '0;
          b_op[i][j] <= '0;
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          acc[i][j]  <= '0;
        end
      end
    end else if (accept) begin
      t <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          a_op[i][j] <= a_flat[(i*N+j)*DW +: DW];
          b_op[i][j] <= b_flat[(i*N+j)*DW +: DW];
          a_pe[i][j] <= '0;
          b_pe[i][j] <= '0;
          if (!in_accum) acc[i][j] <= '0;
        end
      end
    end else if (state == RUN) begin
      t <= t + 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if (j == 0) a_pe[i][j] <= a_inj[i];
          else        a_pe[i][j] <= a_pe[i][j-1];
          if (i == 0) b_pe[i][j] <= b_inj[j];
          else        b_pe[i][j] <= b_pe[i-1][j];
          acc[i][j] <= acc_nx[i][j];
        end
      end
    end
  end

  // Result bus driven straight from the accumulators
  always_comb begin
    c_flat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        c_flat[(i*N+j)*AW +: AW] = acc[i][j];
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul.sv
// Self-checking bench for systolic_matmul: default 4x4 instance against a plain
// matrix-product model, plus a 2x2 DW=4 AW=6 instance for the wrap case.
module tb_systolic_matmul;

  localparam int N4 = 4, DW4 = 3, AW4 = 8;
  localparam int N2 = 2, DW2 = 4, AW2 = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                   in_valid = 1'b0, in_ready, in_accum = 1'b0;
  logic [N4*N4*DW4-1:0]   a_flat = '0, b_flat = '0;
  logic                   out_valid, out_ready = 1'b0, busy;
  logic [N4*N4*AW4-1:0]   c_flat;

  logic                   v2 = 1'b0, r2, acc2 = 1'b0;
  logic [N2*N2*DW2-1:0]   a2 = '0, b2 = '0;
  logic                   ov2, or2 = 1'b0, busy2;
  logic [N2*N2*AW2-1:0]   c2;

  int checks = 0;
  int errors = 0;

  int ma[4][4];
  int mb[4][4];
  int mc[4][4];

  always #5 clk = ~clk;

  systolic_matmul dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_accum(in_accum), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .c_flat(c_flat), .busy(busy)
  );

  systolic_matmul #(.N(N2), .DW(DW2), .AW(AW2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
    .in_accum(acc2), .a_flat(a2), .b_flat(b2),
    .out_valid(ov2), .out_ready(or2), .c_flat(c2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N4*N4*DW4-1:0] pack_op(input int m[4][4]);
    logic [N4*N4*DW4-1:0] v;
    v = '0;
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++)
        v[(r*N4+c)*DW4 +: DW4] = 3'(m[r][c]);
    return v;
  endfunction

  function automatic logic [127:0] pack_mc();
    logic [127:0] v;
    v = '0;
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++)
        v[(r*N4+c)*AW4 +: AW4] = 8'(mc[r][c]);
    return v;
  endfunction

  // Reference: C = (accum ? C : 0) + A*B, modulo 2^AW
  task automatic model(input bit accum);
    for (int r = 0; r < N4; r++)
      for (int c = 0; c < N4; c++) begin
        int s;
        s = accum ? mc[r][c] : 0;
        for (int k = 0; k < N4; k++) s += ma[r][k] * mb[k][c];
        mc[r][c] = s % 256;
      end
  endtask

  task automatic run_op(input bit accum, input int hold, input string tag);
    int lat, bcnt;
    @(negedge clk);
    chk({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    a_flat = pack_op(ma); b_flat = pack_op(mb); in_accum = accum; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_accum = 1'b0;
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    model(accum);
    chk({tag, "_latency"}, 128'(lat), 128'(11));
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'(11));
    chk({tag, "_c"}, 128'(c_flat), pack_mc());
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      chk({tag, "_hold_c"}, 128'(c_flat), pack_mc());
      chk({tag, "_hold_in_ready"}, 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 128'(in_ready), 128'(1));
    chk({tag, "_idle_out_valid"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int seen, lat2, e2;
    logic [N2*N2*AW2-1:0] exp2;

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mc[r][c] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_c", 128'(c_flat), 128'(0));

    // Identity times indexed B, with 5 cycles of backpressure
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = (r*4 + c) % 8;
      end
    run_op(1'b0, 5, "ident");

    // All-max operands: every element 4*49 = 196
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 7; mb[r][c] = 7; end
    run_op(1'b0, 0, "max");
    chk("max_c_const", 128'(c_flat), {16{8'hC4}});

    // All-ones, clear then accumulate
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin ma[r][c] = 1; mb[r][c] = 1; end
    run_op(1'b0, 0, "ones_clr");
    run_op(1'b1, 1, "ones_acc");
    chk("ones_acc_const", 128'(c_flat), {16{8'h08}});

    // Randomized operands with random accumulate flag
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          ma[r][c] = $urandom_range(0, 7);
          mb[r][c] = $urandom_range(0, 7);
        end
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 2), "rand");
    end

    // Reset mid-run at step t=5
    @(negedge clk);
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    a_flat = pack_op(ma); b_flat = pack_op(mb); in_accum = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_accum = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", 128'(busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) mc[r][c] = 0;
    chk("midrst_in_ready_after", 128'(in_ready), 128'(1));
    chk("midrst_c", 128'(c_flat), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    seen = 0;
    for (int h = 0; h < 15; h++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    chk("midrst_no_valid", 128'(seen), 128'(0));

    // Reset together with in_valid: nothing accepted
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstvalid_busy", 128'(busy), 128'(0));
    chk("rstvalid_in_ready", 128'(in_ready), 128'(1));

    // Accumulate after reset starts from zero
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ma[r][c] = $urandom_range(0, 7);
        mb[r][c] = $urandom_range(0, 7);
      end
    run_op(1'b1, 0, "post_rst_acc");

    // 2x2, DW=4, AW=6, all 15: each element 450 mod 64 = 2, latency 5
    @(negedge clk);
    chk("n2_in_ready", 128'(r2), 128'(1));
    a2 = '1; b2 = '1; acc2 = 1'b0; v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    lat2 = 0;
    while (!ov2 && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    e2 = (N2 * 15 * 15) % 64;
    exp2 = '0;
    for (int q = 0; q < N2*N2; q++) exp2[q*AW2 +: AW2] = 6'(e2);
    chk("n2_latency", 128'(lat2), 128'(5));
    chk("n2_c", 128'(c2), 128'(exp2));
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    chk("n2_idle", 128'(r2), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
